mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage: consumes EX results (result, store data, control, opcode) and performs lw/sw
//  against a data memory over a req/ack handshake. Stalls the upstream pipeline while an access is
//  outstanding; presents a registered MEM/WB bundle with one-cycle wb_valid per retired instruction.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in ACCESS waiting for dmem_ack before abort (1..65535)
//  ALIGN_CHECK     1    1: lw/sw with addr[1:0]!=0 is faulted, no memory access; 0: no check
// PORTS
//  clock        in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-low
//  in_valid     in   1   EX bundle valid this cycle; ignored while stall_out=1
//  alu_result   in   32  EX result; memory byte address for lw/sw
//  alu_data     in   32  EX operand; store data for sw
//  control_mem  in   8   control byte from EX, forwarded untouched unless faulted
//  opcode_mem   in   6   opcode from EX (lw=6'b100011, sw=6'b101011)
//  stall_out    out  1   upstream must hold its bundle while 1
//  dmem_req     out  1   access request, held until ack
//  dmem_we      out  1   1=write (sw), 0=read (lw); valid with dmem_req
//  dmem_addr    out  32  word-aligned address, stable while dmem_req
//  dmem_wdata   out  32  store data, stable while dmem_req
//  dmem_rdata   in   32  read data, sampled on the cycle dmem_ack=1
//  dmem_ack     in   1   completes the outstanding request; ignored when dmem_req=0
//  wb_valid     out  1   one-cycle pulse: wb_* bundle valid
//  wb_data      out  32  dmem_rdata for lw, alu_result otherwise
//  wb_control   out  8   forwarded control; 8'h00 on fault
//  wb_opcode    out  6   forwarded opcode
//  fault        out  1   one-cycle pulse with wb_valid on misalign or timeout
// BEHAVIOUR
//  - Reset (reset=0 at edge): state=IDLE; all outputs 0; counter 0. Reset wins over every event.
//  - FSM states IDLE, ACCESS. stall_out = (state==ACCESS), combinational from state.
//  - IDLE, in_valid=1, non-memory opcode: next edge wb_valid=1, wb_data=alu_result, wb_control/
//    wb_opcode forwarded. Latency 1 cycle; back-to-back every cycle.
//  - IDLE, in_valid=1, lw/sw, aligned: capture addr/data/control/opcode into holding regs; ->ACCESS;
//    wb_valid=0. Misaligned with ALIGN_CHECK=1: no ACCESS, next edge wb_valid=1, fault=1, wb_control=0.
//  - ACCESS: dmem_req=1, dmem_we=(op==sw), addr/wdata from holding regs, constant for whole state.
//    Counter increments each ACCESS cycle without ack.
//  - dmem_ack=1 in ACCESS (earliest: first ACCESS cycle): next edge ->IDLE, dmem_req=0, wb_valid=1,
//    wb_data=dmem_rdata (lw) or held address (sw). Total lw latency = 1 + ack-wait cycles + 1.
//  - Counter reaches TIMEOUT_CYCLES without ack: ->IDLE, wb_valid=1, fault=1, wb_control=0, wb_data=0.
//    Ack on the same cycle as timeout: ack wins, normal completion.
//  - in_valid during ACCESS ignored (upstream is holding). First bundle after return to IDLE is
//    accepted in that IDLE cycle.
//  - dmem_ack while IDLE: ignored, no state change.
//  - Reset during ACCESS: next edge dmem_req=0, transaction abandoned, no wb_valid, no fault.
//  - wb_* hold last values when wb_valid=0; only wb_valid/fault are pulses.
//  - Counter width: $clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS.
// STRUCTURE
//  - Shared header mips_defs.vh: opcode constants (OP_RTYPE, OP_LW, OP_SW, ...), state encodings
//    ST_IDLE/ST_ACCESS, control byte bit positions.
//  - One sub-module: mem_timeout_counter (clear, enable, terminal-count out, param TIMEOUT_CYCLES).
//  - FSM, holding regs and MEM/WB output regs in this module.
// TESTING
//  1 R-type: in_valid, op=0, alu_result=32'h0000_0007 -> next cycle wb_valid=1, wb_data=7, stall_out=0.
//  2 lw addr 32'h0000_0010, ack after 3 wait cycles, rdata=32'hDEAD_BEEF -> req held 4 cycles, addr
//    stable, stall 4 cycles, then wb_valid=1, wb_data=DEADBEEF, fault=0.
//  3 sw addr 32'h20 data 32'h1234_5678, ack on first ACCESS cycle -> dmem_we=1, wdata=12345678,
//    single-cycle req, wb_valid next edge.
//  4 lw addr 32'h0000_0013, ALIGN_CHECK=1 -> dmem_req never asserts, wb_valid=1, fault=1, wb_control=0.
//  5 TIMEOUT_CYCLES=4, lw never acked -> req for 4 cycles, then IDLE, fault=1; ack on cycle 4 instead
//    -> normal completion, fault=0.
//  6 reset=0 asserted mid-ACCESS of lw -> next edge dmem_req=0, stall_out=0, no wb_valid; late ack ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: opcodes, FSM state encoding and decode helpers for the MEM stage
package mem_access_stage_pkg;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction
endpackage

// File: rtl/mem_access_stage_counter.sv
// mem_timeout_counter: counts unacknowledged ACCESS cycles and flags the last allowed one
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  // wait counter, restarted whenever the stage is not waiting on memory
  always_ff @(posedge clock)
    if (!reset || clear) count <= '0;
    else if (enable) count <= count + W'(1);
  assign terminal = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage performing lw/sw over a req/ack data-memory handshake
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_data,
  input  logic [7:0]  control_mem,
  input  logic [5:0]  opcode_mem,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [7:0]  wb_control,
  output logic [5:0]  wb_opcode,
  output logic        fault
);
  state_t      state, state_next;
  logic [31:0] hold_addr, hold_data;
  logic [7:0]  hold_control;
  logic [5:0]  hold_opcode;
  logic        accept, mem_op, misaligned, start, done, terminal, timeout;
  assign accept     = state == ST_IDLE && in_valid;
  assign mem_op     = is_mem_op(opcode_mem);
  assign misaligned = mem_op && ALIGN_CHECK != 0 && alu_result[1:0] != 2'b00;
  assign start      = accept && mem_op && !misaligned;
  assign done       = state == ST_ACCESS && dmem_ack;
  assign timeout    = state == ST_ACCESS && !dmem_ack && terminal;
  assign stall_out  = state == ST_ACCESS;
  assign dmem_req   = state == ST_ACCESS;
  assign dmem_we    = state == ST_ACCESS && hold_opcode == OP_SW;
  assign dmem_addr  = {hold_addr[31:2], 2'b00};
  assign dmem_wdata = hold_data;
  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .enable  (state == ST_ACCESS && !dmem_ack),
    .terminal(terminal)
  );
  // state register
  always_ff @(posedge clock)
    if (!reset) state <= ST_IDLE;
    else state <= state_next;
  // enter ACCESS on an aligned lw/sw; leave on ack (which beats timeout) or timeout
  always_comb begin
    state_next = state;
    if (start) state_next = ST_ACCESS;
    if (done || timeout) state_next = ST_IDLE;
  end
  // holding regs for the in-flight access and the registered MEM/WB bundle
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_addr    <= '0;
      hold_data    <= '0;
      hold_control <= '0;
      hold_opcode  <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_control   <= '0;
      wb_opcode    <= '0;
      fault        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      if (start) begin
        hold_addr    <= alu_result;
        hold_data    <= alu_data;
        hold_control <= control_mem;
        hold_opcode  <= opcode_mem;
      end else if (accept) begin
        wb_valid   <= 1'b1;
        fault      <= misaligned;
        wb_data    <= alu_result;
        wb_control <= misaligned ? 8'h00 : control_mem;
        wb_opcode  <= opcode_mem;
      end else if (done) begin
        wb_valid   <= 1'b1;
        wb_data    <= hold_opcode == OP_SW ? hold_addr : dmem_rdata;
        wb_control <= hold_control;
        wb_opcode  <= hold_opcode;
      end else if (timeout) begin
        wb_valid   <= 1'b1;
        fault      <= 1'b1;
        wb_data    <= '0;
        wb_control <= 8'h00;
        wb_opcode  <= hold_opcode;
      end
    end
  end
endmodule
